// File: rtl/cmpl_pkg.sv
// cmpl_pkg: shared helpers for the complex datapath blocks (width calc, rounding, saturation).
package cmpl_pkg;

  localparam int MAXW = 128;

  typedef enum logic {ST_IDLE, ST_ACCUM} acc_state_t;

  typedef struct packed {
    logic signed [MAXW-1:0] y;
    logic                   f;
  } sat_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic logic [MAXW-1:0] rnd_const(input int shift);
    logic [MAXW-1:0] c;
    c = '0;
    if (shift > 0) c = MAXW'(1) << (shift - 1);
    return c;
  endfunction

  function automatic sat_t saturate(input logic signed [MAXW-1:0] v, input int ow);
    logic signed [MAXW-1:0] hi, lo;
    sat_t s;
    hi  = (MAXW'(1) << (ow - 1)) - 1;
    lo  = ~hi;
    s.f = (v > hi) || (v < lo);
    s.y = (v > hi) ? hi : (v < lo) ? lo : v;
    return s;
  endfunction

endpackage

// File: rtl/cmpl_round_sat.sv
// cmpl_round_sat: round-half-up arithmetic shift then clip one signed component.
module cmpl_round_sat
  import cmpl_pkg::*;
#(
  parameter int AW    = 34,
  parameter int SHIFT = 4,
  parameter int OW    = 32
) (
  input  logic signed [AW-1:0] i_s,
  output logic signed [OW-1:0] o_y,
  output logic                 o_sat
);

  localparam int RW = AW + 1;
  localparam logic signed [RW-1:0] C_RND = RW'(rnd_const(SHIFT));

  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_shf;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign w_rnd = {i_s[AW-1], i_s} + C_RND;
  assign w_shf = w_rnd >>> SHIFT;

  if (OW >= RW - SHIFT) begin : g_nosat
    logic w_unused;
    assign w_unused = ^w_shf;
    assign o_y      = OW'(w_shf);
    assign o_sat    = 1'b0;
  end else begin : g_sat
    sat_t w_sat;
    logic w_unused;
    assign w_sat    = saturate(MAXW'(w_shf), OW);
    assign w_unused = ^w_sat.y[MAXW-1:OW];
    assign o_y      = w_sat.y[OW-1:0];
    assign o_sat    = w_sat.f;
  end

endmodule

// File: rtl/cmpl_accum_dump.sv
// cmpl_accum_dump: integrate ACC_LEN complex samples, then dump one scaled, saturated result.
module cmpl_accum_dump
  import cmpl_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_LEN   = 16,
  parameter int SHIFT     = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        ivalid,
  input  logic signed [IN_WIDTH-1:0]  data_r,
  input  logic signed [IN_WIDTH-1:0]  data_i,
  output logic                        ovalid,
  output logic signed [OUT_WIDTH-1:0] result_r,
  output logic signed [OUT_WIDTH-1:0] result_i,
  output logic                        overflow,
  output logic                        busy
);

  localparam int CW = clog2(ACC_LEN);
  localparam int AW = IN_WIDTH + CW;

  logic        [CW-1:0]        r_cnt;
  logic signed [AW-1:0]        r_acc_r, r_acc_i;
  logic                        r_ovalid, r_ovf;
  logic signed [OUT_WIDTH-1:0] r_res_r, r_res_i;

  acc_state_t                  w_state;
  logic        [CW-1:0]        w_cnt_nxt;
  logic signed [AW-1:0]        w_sum_r, w_sum_i, w_acc_r_nxt, w_acc_i_nxt;
  logic                        w_last, w_dump, w_sat_r, w_sat_i;
  logic signed [OUT_WIDTH-1:0] w_y_r, w_y_i;

  always_comb begin
    w_state     = (r_cnt == '0) ? ST_IDLE : ST_ACCUM;
    // IDLE ignores the stale accumulator so a new block starts from the sample itself.
    w_sum_r     = (w_state == ST_IDLE ? '0 : r_acc_r) + AW'(data_r);
    w_sum_i     = (w_state == ST_IDLE ? '0 : r_acc_i) + AW'(data_i);
    w_last      = ivalid && (r_cnt == CW'(ACC_LEN - 1));
    w_dump      = w_last && !clear;
    w_cnt_nxt   = clear ? '0 : !ivalid ? r_cnt : w_last ? '0 : r_cnt + 1'b1;
    w_acc_r_nxt = (ivalid && !clear) ? w_sum_r : r_acc_r;
    w_acc_i_nxt = (ivalid && !clear) ? w_sum_i : r_acc_i;
  end

  cmpl_round_sat #(.AW(AW), .SHIFT(SHIFT), .OW(OUT_WIDTH)) u_rs_r (
    .i_s   (w_sum_r),
    .o_y   (w_y_r),
    .o_sat (w_sat_r)
  );

  cmpl_round_sat #(.AW(AW), .SHIFT(SHIFT), .OW(OUT_WIDTH)) u_rs_i (
    .i_s   (w_sum_i),
    .o_y   (w_y_i),
    .o_sat (w_sat_i)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc_r  <= '0;
      r_acc_i  <= '0;
      r_ovalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_res_r  <= '0;
      r_res_i  <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_acc_r  <= w_acc_r_nxt;
      r_acc_i  <= w_acc_i_nxt;
      r_ovalid <= w_dump;
      if (w_dump) begin
        r_res_r <= w_y_r;
        r_res_i <= w_y_i;
        r_ovf   <= w_sat_r | w_sat_i;
      end
    end
  end

  assign ovalid   = r_ovalid;
  assign result_r = r_res_r;
  assign result_i = r_res_i;
  assign overflow = r_ovf;
  assign busy     = (r_cnt != '0);

endmodule

// File: tb/tb_cmpl_accum_dump.sv
// tb_cmpl_accum_dump: three configurations share one stimulus stream; per-instance scoreboards.
module tb_cmpl_accum_dump;

  typedef struct {
    int r;
    int i;
    int o;
    int c;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n, clear, ivalid;
  logic signed [31:0] data_r, data_i;

  logic ov0, of0, bz0, ov1, of1, bz1, ov2, of2, bz2;
  logic signed [31:0] rr0, ri0, rr1, ri1;
  logic signed [15:0] rr2, ri2;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cmpl_accum_dump #(.IN_WIDTH(32), .ACC_LEN(4), .SHIFT(0), .OUT_WIDTH(32)) u_a (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ivalid(ivalid),
    .data_r(data_r), .data_i(data_i), .ovalid(ov0), .result_r(rr0),
    .result_i(ri0), .overflow(of0), .busy(bz0));

  cmpl_accum_dump #(.IN_WIDTH(32), .ACC_LEN(4), .SHIFT(2), .OUT_WIDTH(32)) u_b (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ivalid(ivalid),
    .data_r(data_r), .data_i(data_i), .ovalid(ov1), .result_r(rr1),
    .result_i(ri1), .overflow(of1), .busy(bz1));

  cmpl_accum_dump #(.IN_WIDTH(32), .ACC_LEN(4), .SHIFT(0), .OUT_WIDTH(16)) u_c (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ivalid(ivalid),
    .data_r(data_r), .data_i(data_i), .ovalid(ov2), .result_r(rr2),
    .result_i(ri2), .overflow(of2), .busy(bz2));

  task automatic cmp(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (ov0) begin
      if (q0.size() == 0) cmp("A spurious ovalid", 1, 0);
      else begin
        e = q0.pop_front();
        cmp("A cycle", cyc, e.c);
        cmp("A result_r", int'(rr0), e.r);
        cmp("A result_i", int'(ri0), e.i);
        cmp("A overflow", int'(of0), e.o);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (ov1) begin
      if (q1.size() == 0) cmp("B spurious ovalid", 1, 0);
      else begin
        e = q1.pop_front();
        cmp("B cycle", cyc, e.c);
        cmp("B result_r", int'(rr1), e.r);
        cmp("B result_i", int'(ri1), e.i);
        cmp("B overflow", int'(of1), e.o);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (ov2) begin
      if (q2.size() == 0) cmp("C spurious ovalid", 1, 0);
      else begin
        e = q2.pop_front();
        cmp("C cycle", cyc, e.c);
        cmp("C result_r", int'(rr2), e.r);
        cmp("C result_i", int'(ri2), e.i);
        cmp("C overflow", int'(of2), e.o);
      end
    end
  end

  task automatic smp(input int r, input int i);
    data_r = r;
    data_i = i;
    ivalid = 1'b1;
    @(posedge clock);
    #1 ivalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic last(input int r, input int i,
                      input int ar, input int ai, input int ao,
                      input int br, input int bi, input int bo,
                      input int cr, input int ci, input int co);
    data_r = r;
    data_i = i;
    ivalid = 1'b1;
    @(posedge clock);
    #1 ivalid = 1'b0;
    q0.push_back('{ar, ai, ao, cyc});
    q1.push_back('{br, bi, bo, cyc});
    q2.push_back('{cr, ci, co, cyc});
  endtask

  task automatic chk_zero(input string nm);
    cmp({nm, " ovalid"}, int'(ov0 | ov1 | ov2), 0);
    cmp({nm, " A result"}, int'(rr0 | ri0), 0);
    cmp({nm, " B result"}, int'(rr1 | ri1), 0);
    cmp({nm, " C result"}, int'(rr2 | ri2), 0);
    cmp({nm, " overflow"}, int'(of0 | of1 | of2), 0);
    cmp({nm, " busy"}, int'(bz0 | bz1 | bz2), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    ivalid  = 1'b0;
    data_r  = 0;
    data_i  = 0;
    #2 chk_zero("reset");
    #10 reset_n = 1'b1;
    idle(2);

    // (3+4j)(1+2j) = -5+10j, four in a row
    smp(-5, 10);
    cmp("busy after sample 1", int'(bz0), 1);
    smp(-5, 10);
    smp(-5, 10);
    last(-5, 10, -20, 40, 0, -5, 10, 0, -20, 40, 0);
    cmp("busy after dump", int'(bz0), 0);
    idle(2);

    // same block with gaps
    smp(-5, 10);
    idle(2);
    cmp("busy in gap", int'(bz0), 1);
    smp(-5, 10);
    idle(1);
    smp(-5, 10);
    idle(3);
    cmp("busy before last", int'(bz0), 1);
    last(-5, 10, -20, 40, 0, -5, 10, 0, -20, 40, 0);
    idle(1);

    // sum (6,-6): SHIFT=2 -> (2,-1)
    smp(1, -1); smp(2, -2); smp(3, -3);
    last(0, 0, 6, -6, 0, 2, -1, 0, 6, -6, 0);
    // sum (2,-2): SHIFT=2 -> (1,0)
    smp(1, -1); smp(1, -1); smp(0, 0);
    last(0, 0, 2, -2, 0, 1, 0, 0, 2, -2, 0);

    // 16-bit output saturates both ways
    smp(20000, -20000); smp(20000, -20000); smp(20000, -20000);
    last(20000, -20000, 80000, -80000, 0, 20000, -20000, 0, 32767, -32768, 1);
    smp(1, 1); smp(1, 1); smp(1, 1);
    last(1, 1, 4, 4, 0, 1, 1, 0, 4, 4, 0);
    idle(2);

    // back-to-back blocks: k=1..8
    smp(1, -1); smp(2, -2); smp(3, -3);
    last(4, -4, 10, -10, 0, 3, -2, 0, 10, -10, 0);
    smp(5, -5); smp(6, -6); smp(7, -7);
    last(8, -8, 26, -26, 0, 7, -6, 0, 26, -26, 0);
    idle(2);

    // clear after two samples drops the partial sum and the coincident sample
    smp(9, 9); smp(9, 9);
    data_r = 9; data_i = 9; ivalid = 1'b1; clear = 1'b1;
    @(posedge clock);
    #1 begin ivalid = 1'b0; clear = 1'b0; end
    cmp("busy after clear", int'(bz0), 0);
    smp(1, 2); smp(1, 2); smp(1, 2);
    last(1, 2, 4, 8, 0, 1, 2, 0, 4, 8, 0);
    idle(1);

    // clear on the 4th sample suppresses the dump; held results stay
    smp(7, 7); smp(7, 7); smp(7, 7);
    data_r = 7; data_i = 7; ivalid = 1'b1; clear = 1'b1;
    @(posedge clock);
    #1 begin ivalid = 1'b0; clear = 1'b0; end
    cmp("busy after clear on last", int'(bz0), 0);
    idle(3);
    cmp("held A result_r", int'(rr0), 4);
    cmp("held A result_i", int'(ri0), 8);

    // reset mid-block
    smp(50, 50); smp(50, 50);
    reset_n = 1'b0;
    #1 chk_zero("mid reset");
    @(posedge clock);
    #1 reset_n = 1'b1;
    idle(1);
    smp(2, 3); smp(2, 3); smp(2, 3);
    last(2, 3, 8, 12, 0, 2, 3, 0, 8, 12, 0);
    idle(3);

    cmp("A pending", q0.size(), 0);
    cmp("B pending", q1.size(), 0);
    cmp("C pending", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
